mult_fu_pipe: RTL and testbench
===============================

Name: mult_fu_pipe

Overview:
- Pipelined integer multiply functional unit. Accepts one RV32M multiply per cycle from issue and returns results to the CDB in issue order through a small completion buffer with a valid/ack handshake.
- Supersedes the single-op start/done multiplier FU. Adds:
  - multiple ops in flight;
  - all four MUL/MULH/MULHSU/MULHU modes;
  - back-pressure;
  - flush on mispredict squash.

Parameters:
- XLEN, 32, operand/result width.
- STAGES, 4, multiplier pipeline depth. Must divide 2*XLEN; each stage folds 2*XLEN/STAGES multiplier bits.
- TAG_W, 5, ROB tag width.
- OUT_DEPTH, 2, completion buffer entries (>=1).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  op presented by issue stage
- issue_ready  out  1  FU can accept op this cycle
- rs1_value  in  XLEN  multiplicand
- rs2_value  in  XLEN  multiplier
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; others are treated as MUL
- rob_tag  in  TAG_W  destination ROB tag
- flush  in  1  squash all in-flight and buffered ops
- cdb_ack  in  1  CDB consumed head result
- out_valid  out  1  head result available
- out_value  out  XLEN  head result
- out_rob_tag  out  TAG_W  head result tag

Behaviour:
- Reset/clock: reset is synchronous, active-high; clock is clock. Reset is identical in effect to flush plus clearing all datapath registers. Reset values:
  - out_valid=0, out_value=0, out_rob_tag=0, issue_ready=1;
  - all stage valid bits, buffer pointers and count are 0.
- Accept: an op is accepted on a rising edge where issue_valid && issue_ready && !flush. Operands, funct3 and tag are captured into stage 0 at that edge. Inputs need not be held afterwards.
- Operand extension to 2*XLEN:
  - MUL: either extension, since only the low half is used.
  - MULH: both sign-extended.
  - MULHSU: rs1 sign-extended, rs2 zero-extended.
  - MULHU: both zero-extended.
- Result selection: MUL returns product[XLEN-1:0]; the three high variants return product[2*XLEN-1:XLEN].
- Pipeline:
  - Each stage carries valid, tag, mode, the partially shifted multiplier/multiplicand and the running sum.
  - An op accepted at edge t is written into the completion buffer at edge t+STAGES when there is no stall.
  - out_valid rises in the cycle after that edge when the buffer was empty. There is no bypass.
- Stall:
  - stall = last stage valid && buffer full && !(out_valid && cdb_ack).
  - On stall, every stage holds and issue_ready=0.
  - Without a stall, issue_ready=1 and all stages advance together. Bubbles are not compressed.
- Completion buffer:
  - FIFO, OUT_DEPTH entries; out_* driven from the head.
  - Pop on out_valid && cdb_ack.
  - Simultaneous push and pop when full is legal: the count is unchanged and there is no stall.
  - Pointers wrap modulo OUT_DEPTH.
  - cdb_ack while out_valid=0 is ignored.
  - out_value and out_rob_tag hold stable while out_valid=1 and not acked.
- Ordering: results leave strictly in acceptance order.
- Capacity: at most STAGES+OUT_DEPTH ops are outstanding.
- Flush:
  - At the edge where flush=1, all stage valid bits and the buffer count and pointers clear.
  - An issue_valid in the same cycle is dropped.
  - out_valid=0 from the next cycle.
  - cdb_ack in a flush cycle has no further effect.
  - issue_ready=1 in the cycle after a flush.
- Reset mid-operation discards everything. The first op accepted after reset has normal latency.
- Concurrency: no combinational path from cdb_ack to out_value. issue_ready may depend combinationally on cdb_ack through the stall term.

Test Plan:
- Reset, then MUL rs1=3, rs2=0xFFFFFFFE, tag=7, cdb_ack=1 -> out_valid high exactly STAGES+1 cycles after the accept edge, out_value=0xFFFFFFFA, out_rob_tag=7, single-cycle pulse.
- Back-to-back with ack held high:
  - MULH 0x80000000*0x80000000 -> 0x40000000;
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF;
  - MUL 0x12345678*0x10 -> 0x23456780.
  - Results are returned on consecutive cycles in that order.
- cdb_ack=0, issue 7 ops tags 1..7 -> issue_ready falls after the 6th acceptance (STAGES+OUT_DEPTH), op 7 is held. Then pulse ack one cycle at a time -> tags 1..7 emerge in order, with no loss or duplication.
- Buffer full with last stage valid, cdb_ack=1 and a new issue in the same cycle -> no stall, issue accepted, head advances, count stays OUT_DEPTH.
- Three ops in flight plus one buffered, assert flush with issue_valid=1 -> next cycle out_valid=0 and issue_ready=1. No result from the squashed ops or the dropped issue appears within 2*STAGES cycles. A new MUL 5*5 then returns 25.
- Assert reset mid-pipeline with the buffer non-empty -> all outputs take their reset values the next cycle. A subsequent op completes with normal latency.

Source files
------------

// File: rtl/mult_fu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mult_fu_pipe
// Purpose  : Pipelined RV32M integer multiply unit (MUL/MULH/MULHSU/MULHU)
//            with an in-order completion buffer, CDB valid/ack handshake,
//            whole-pipe back-pressure and mispredict flush.
// Revision : 1.0 - initial pipelined release
// ============================================================================
module mult_fu_pipe #(
   parameter int XLEN      = 32,
   parameter int STAGES    = 4,
   parameter int TAG_W     = 5,
   parameter int OUT_DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [XLEN-1:0]  rs1_value,
   input  logic [XLEN-1:0]  rs2_value,
   input  logic [2:0]       funct3,
   input  logic [TAG_W-1:0] rob_tag,
   input  logic             flush,
   input  logic             cdb_ack,
   output logic             out_valid,
   output logic [XLEN-1:0]  out_value,
   output logic [TAG_W-1:0] out_rob_tag
);

   localparam int PW    = 2 * XLEN;
   localparam int CHUNK = PW / STAGES;
   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);

   localparam logic [1:0] MODE_MUL    = 2'd0;
   localparam logic [1:0] MODE_MULH   = 2'd1;
   localparam logic [1:0] MODE_MULHSU = 2'd2;
   localparam logic [1:0] MODE_MULHU  = 2'd3;

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);

   // Pipeline stage state: multiplicand shifts left and multiplier shifts
   // right by CHUNK each stage while the running sum accumulates partials.
   logic             st_valid  [STAGES];
   logic [TAG_W-1:0] st_tag    [STAGES];
   logic [1:0]       st_mode   [STAGES];
   logic [PW-1:0]    st_mcand  [STAGES];
   logic [PW-1:0]    st_mplier [STAGES];
   logic [PW-1:0]    st_sum    [STAGES];

   // Completion buffer
   logic [XLEN-1:0]  buf_value [OUT_DEPTH];
   logic [TAG_W-1:0] buf_tag   [OUT_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic             full;
   logic             pop;
   logic             push;
   logic             stall;
   logic             accept;
   logic [1:0]       in_mode;
   logic [PW-1:0]    in_mcand;
   logic [PW-1:0]    in_mplier;
   logic [PW-1:0]    final_prod;
   logic [XLEN-1:0]  result;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake and back-pressure; a same-cycle pop frees the slot a push needs
   always_comb begin
      full        = (count == FULL_CNT);
      out_valid   = (count != '0);
      pop         = out_valid && cdb_ack;
      stall       = st_valid[STAGES-1] && full && !pop;
      issue_ready = !stall;
      accept      = issue_valid && issue_ready && !flush;
      push        = st_valid[STAGES-1] && !stall;
      out_value   = buf_value[head];
      out_rob_tag = buf_tag[head];
   end

   // Decode funct3 and extend operands to the full product width
   always_comb begin
      case (funct3)
         3'b001:  in_mode = MODE_MULH;
         3'b010:  in_mode = MODE_MULHSU;
         3'b011:  in_mode = MODE_MULHU;
         default: in_mode = MODE_MUL;
      endcase
      if (in_mode == MODE_MULH || in_mode == MODE_MULHSU)
         in_mcand = {{XLEN{rs1_value[XLEN-1]}}, rs1_value};
      else
         in_mcand = {{XLEN{1'b0}}, rs1_value};
      if (in_mode == MODE_MULH)
         in_mplier = {{XLEN{rs2_value[XLEN-1]}}, rs2_value};
      else
         in_mplier = {{XLEN{1'b0}}, rs2_value};
   end

   // Last fold: only the top CHUNK multiplier bits remain (upper bits are
   // zero after the right shifts), then pick the low or high product half
   always_comb begin
      final_prod = st_sum[STAGES-1] + st_mcand[STAGES-1] * st_mplier[STAGES-1];
      result     = (st_mode[STAGES-1] == MODE_MUL) ? final_prod[XLEN-1:0]
                                                   : final_prod[PW-1:XLEN];
   end

   // Stage registers: capture into stage 0, fold CHUNK bits per advance
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            st_valid[i]  <= 1'b0;
            st_tag[i]    <= '0;
            st_mode[i]   <= MODE_MUL;
            st_mcand[i]  <= '0;
            st_mplier[i] <= '0;
            st_sum[i]    <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < STAGES; i++)
            st_valid[i] <= 1'b0;
      end else if (!stall) begin
         st_valid[0]  <= accept;
         st_tag[0]    <= rob_tag;
         st_mode[0]   <= in_mode;
         st_mcand[0]  <= in_mcand;
         st_mplier[0] <= in_mplier;
         st_sum[0]    <= '0;
         for (int i = 1; i < STAGES; i++) begin
            st_valid[i]  <= st_valid[i-1];
            st_tag[i]    <= st_tag[i-1];
            st_mode[i]   <= st_mode[i-1];
            st_sum[i]    <= st_sum[i-1] + st_mcand[i-1] * PW'(st_mplier[i-1][CHUNK-1:0]);
            st_mcand[i]  <= st_mcand[i-1] << CHUNK;
            st_mplier[i] <= st_mplier[i-1] >> CHUNK;
         end
      end
   end

   // Completion FIFO: push finished ops at the tail, pop the head on ack
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < OUT_DEPTH; i++) begin
            buf_value[i] <= '0;
            buf_tag[i]   <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            buf_value[tail] <= result;
            buf_tag[tail]   <= st_tag[STAGES-1];
            tail            <= next_ptr(tail);
         end
         if (pop)
            head <= next_ptr(head);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_fu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_fu_pipe
// Purpose  : Self-checking bench for mult_fu_pipe: directed corner cases plus
//            randomized traffic scored against an in-order arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_fu_pipe;

   localparam int XLEN      = 32;
   localparam int STAGES    = 4;
   localparam int TAG_W     = 5;
   localparam int OUT_DEPTH = 2;

   logic             clock = 1'b0;
   logic             reset;
   logic             issue_valid;
   logic             issue_ready;
   logic [XLEN-1:0]  rs1_value;
   logic [XLEN-1:0]  rs2_value;
   logic [2:0]       funct3;
   logic [TAG_W-1:0] rob_tag;
   logic             flush;
   logic             cdb_ack;
   logic             out_valid;
   logic [XLEN-1:0]  out_value;
   logic [TAG_W-1:0] out_rob_tag;

   mult_fu_pipe #(
      .XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)
   ) dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .rs1_value(rs1_value), .rs2_value(rs2_value),
      .funct3(funct3), .rob_tag(rob_tag),
      .flush(flush), .cdb_ack(cdb_ack),
      .out_valid(out_valid), .out_value(out_value), .out_rob_tag(out_rob_tag)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected results in acceptance order: {tag, value}
   logic [TAG_W+XLEN-1:0] exp_q [$];
   logic [TAG_W+XLEN-1:0] exp_word;
   logic                  hold_valid = 1'b0;
   logic [TAG_W+XLEN-1:0] hold_word;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Architectural RV32M multiply in 64-bit arithmetic
   function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f)
         3'b001:  p = sa * sb;
         3'b010:  p = sa * longint'(ub);
         3'b011:  p = ua * ub;
         default: p = ua * ub;
      endcase
      return (f == 3'b001 || f == 3'b010 || f == 3'b011) ? p[63:32] : p[31:0];
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 3));
         default: return $urandom();
      endcase
   endfunction

   // Scoreboard: sampled mid-cycle so inputs and outputs are settled
   always @(negedge clock) begin
      if (reset || flush) begin
         exp_q.delete();
         hold_valid = 1'b0;
      end else begin
         if (hold_valid)
            check("hold_stable", 64'({out_valid, out_rob_tag, out_value}), 64'({1'b1, hold_word}));
         hold_valid = out_valid && !cdb_ack;
         hold_word  = {out_rob_tag, out_value};
         if (out_valid) begin
            if (exp_q.size() == 0)
               check("spurious_out", 64'(out_valid), 64'd0);
            else if (cdb_ack) begin
               exp_word = exp_q.pop_front();
               check("result", 64'({out_rob_tag, out_value}), 64'(exp_word));
            end
         end
         if (issue_valid && issue_ready) begin
            exp_q.push_back({rob_tag, ref_mul(funct3, rs1_value, rs2_value)});
            check("capacity", 64'(exp_q.size() <= STAGES + OUT_DEPTH), 64'd1);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] t);
      issue_valid = 1'b1;
      funct3      = f;
      rs1_value   = a;
      rs2_value   = b;
      rob_tag     = t;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         if (issue_ready) begin
            tick();
            issue_valid = 1'b0;
            return;
         end
         tick();
      end
      check("issue_timeout", 64'd0, 64'd1);
      issue_valid = 1'b0;
   endtask

   task automatic wait_out_valid();
      for (int k = 0; k < 40; k++) begin
         if (out_valid) return;
         tick();
      end
      check("out_valid_timeout", 64'd0, 64'd1);
   endtask

   // Issue one op with ack held high and verify the exact completion cycle
   task automatic latency_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [TAG_W-1:0] t);
      issue_op(f, a, b, t);
      for (int k = 1; k <= STAGES + 1; k++) begin
         tick();
         check({tag, "_valid"}, 64'(out_valid), 64'(k == STAGES));
         if (k == STAGES) begin
            check({tag, "_value"}, 64'(out_value), 64'(ref_mul(f, a, b)));
            check({tag, "_tag"}, 64'(out_rob_tag), 64'(t));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      reset = 1'b1; issue_valid = 1'b0; rs1_value = '0; rs2_value = '0;
      funct3 = '0; rob_tag = '0; flush = 1'b0; cdb_ack = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_value", 64'(out_value), 64'd0);
      check("rst_out_tag", 64'(out_rob_tag), 64'd0);
      check("rst_issue_ready", 64'(issue_ready), 64'd1);

      // Single MUL latency and one-cycle pulse
      cdb_ack = 1'b1;
      latency_op("lat_mul", 3'b000, 32'd3, 32'hFFFF_FFFE, 5'd7);
      check("lat_mul_const", 64'(ref_mul(3'b000, 32'd3, 32'hFFFF_FFFE)), 64'hFFFF_FFFA);

      // Back-to-back, all four modes, ack held high
      issue_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1);
      issue_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      issue_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      issue_op(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd4);
      wait_out_valid();
      begin
         logic [31:0] b2b_exp [4];
         b2b_exp[0] = 32'h4000_0000; b2b_exp[1] = 32'hFFFF_FFFE;
         b2b_exp[2] = 32'hFFFF_FFFF; b2b_exp[3] = 32'h2345_6780;
         for (int i = 0; i < 4; i++) begin
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_value", 64'(out_value), 64'(b2b_exp[i]));
            check("b2b_tag", 64'(out_rob_tag), 64'(i + 1));
            tick();
         end
      end

      // Fill to capacity with no ack
      cdb_ack = 1'b0;
      for (int t = 1; t <= STAGES + OUT_DEPTH; t++)
         issue_op(3'($urandom_range(0, 7)), $urandom(), $urandom(), 5'(t));
      issue_valid = 1'b1; funct3 = 3'b011; rs1_value = $urandom(); rs2_value = $urandom();
      rob_tag = 5'd7;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("full_stall", 64'(issue_ready), 64'd0);
         tick();
      end
      check("full_head_tag", 64'(out_rob_tag), 64'd1);

      // Push and pop in the same cycle while full: no stall, op 7 accepted
      cdb_ack = 1'b1;
      @(negedge clock);
      check("ack_unstall", 64'(issue_ready), 64'd1);
      tick();
      cdb_ack = 1'b0; issue_valid = 1'b0;
      @(negedge clock);
      check("pp_head_tag", 64'(out_rob_tag), 64'd2);
      check("pp_still_full", 64'(issue_ready), 64'd0);
      tick();
      for (int t = 2; t <= 7; t++) begin
         wait_out_valid();
         check("drain_tag", 64'(out_rob_tag), 64'(t));
         cdb_ack = 1'b1; tick(); cdb_ack = 1'b0; tick();
      end
      tick(); tick();
      check("drain_empty", 64'(out_valid), 64'd0);

      // Flush with three in flight and one buffered, plus a dropped issue
      for (int t = 10; t < 14; t++)
         issue_op(3'b000, $urandom(), $urandom(), 5'(t));
      tick();
      flush = 1'b1; issue_valid = 1'b1; rob_tag = 5'd20; funct3 = 3'b000;
      tick();
      flush = 1'b0; issue_valid = 1'b0;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_issue_ready", 64'(issue_ready), 64'd1);
      cdb_ack = 1'b1;
      for (int k = 0; k < 2 * STAGES; k++) begin
         tick();
         check("flush_quiet", 64'(out_valid), 64'd0);
      end
      issue_op(3'b000, 32'd5, 32'd5, 5'd3);
      wait_out_valid();
      check("post_flush_value", 64'(out_value), 64'd25);
      check("post_flush_tag", 64'(out_rob_tag), 64'd3);
      tick();

      // Reset mid-operation with a non-empty buffer
      cdb_ack = 1'b0;
      for (int t = 0; t < 3; t++)
         issue_op(3'b001, $urandom(), $urandom(), 5'(t + 20));
      wait_out_valid();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_value", 64'(out_value), 64'd0);
      check("mid_rst_tag", 64'(out_rob_tag), 64'd0);
      check("mid_rst_ready", 64'(issue_ready), 64'd1);
      cdb_ack = 1'b1;
      ra = $urandom(); rb = $urandom();
      latency_op("post_rst", 3'b011, ra, rb, 5'd9);

      // Randomized traffic with back-pressure and occasional flush
      for (int c = 0; c < 600; c++) begin
         issue_valid = ($urandom_range(0, 99) < 70);
         funct3      = 3'($urandom_range(0, 7));
         rs1_value   = pick_operand();
         rs2_value   = pick_operand();
         rob_tag     = 5'($urandom());
         cdb_ack     = ($urandom_range(0, 99) < 60);
         flush       = ($urandom_range(0, 99) < 2);
         tick();
      end
      flush = 1'b0; issue_valid = 1'b0; cdb_ack = 1'b1;
      for (int k = 0; k < 40 && exp_q.size() != 0; k++)
         tick();
      check("rand_drain", 64'(exp_q.size()), 64'd0);
      tick();
      check("rand_idle", 64'(out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
